fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fq_ring.sv | 53 +++++
 rtl/fetch_queue.sv | 67 ++++++
 tb/tb_fetch_queue.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-queue types: the NOP word and the queue entry layout.
package fetch_pkg;

  localparam int FQ_XLEN = 32;
  localparam logic [FQ_XLEN-1:0] NOP = '0;

  typedef struct packed {
    logic [FQ_XLEN-1:0] instr;
    logic [FQ_XLEN-1:0] pcplus4;
  } fq_entry_t;

endpackage

// File: rtl/fq_ring.sv
// Circular storage for fetched entries: head/tail pointers, occupancy count, flush.
module fq_ring
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fq_entry_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  entry_t                 wdata,
  output entry_t                 rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;

  // Pointers are exactly log2(DEPTH) bits, so increments wrap modulo DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage is not reset; the consumer gates its view with the count.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[tail] <= wdata;
  end

  assign rdata = mem[head];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch PC generator feeding a small FIFO toward decode.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [XLEN-1:0]        imem_addr,
  output logic                   imem_en,
  input  logic [XLEN-1:0]        imem_rdata,
  input  logic                   redirect,
  input  logic [XLEN-1:0]        redirect_pc,
  input  logic                   stall_d,
  output logic                   deq_valid,
  output logic [XLEN-1:0]        deq_instr,
  output logic [XLEN-1:0]        deq_pcplus4,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pcplus4;
  } entry_t;

  logic [XLEN-1:0] pc;
  logic            pop;
  entry_t          wr_entry;
  entry_t          head_entry;

  assign deq_valid = (count != '0);
  assign pop       = deq_valid & ~stall_d & ~redirect;
  // A full queue may still accept a word when the head leaves this same cycle.
  assign imem_en   = ~redirect & ((count < CW'(DEPTH)) | pop);
  assign imem_addr = pc;

  assign wr_entry.instr   = imem_rdata;
  assign wr_entry.pcplus4 = pc + XLEN'(4);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        pc <= RESET_PC;
    else if (redirect) pc <= redirect_pc;
    else if (imem_en)  pc <= pc + XLEN'(4);
  end

  fq_ring #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_ring (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (imem_en),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head_entry),
    .count (count)
  );

  assign deq_instr   = deq_valid ? head_entry.instr   : XLEN'(NOP);
  assign deq_pcplus4 = deq_valid ? head_entry.pcplus4 : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, stall fill, redirect, reset, pointer/PC wrap.
module tb_fetch_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=4, RESET_PC=0 instance
  logic        reset, imem_en, redirect, stall_d, deq_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, deq_instr, deq_pcplus4;
  logic [2:0]  count;

  // DEPTH=8, RESET_PC=0xFFFF_FFF8 instance
  logic        reset8, imem_en8, redirect8, stall8, deq_valid8;
  logic [31:0] imem_addr8, imem_rdata8, redirect_pc8, deq_instr8, deq_pcplus48;
  logic [3:0]  count8;

  // IMEM holds its own address at every word
  assign imem_rdata  = imem_addr;
  assign imem_rdata8 = imem_addr8;

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_en(imem_en),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall_d(stall_d), .deq_valid(deq_valid), .deq_instr(deq_instr),
    .deq_pcplus4(deq_pcplus4), .count(count)
  );

  fetch_queue #(.XLEN(32), .DEPTH(8), .RESET_PC(32'hFFFF_FFF8)) dut8 (
    .clk(clk), .reset(reset8), .imem_addr(imem_addr8), .imem_en(imem_en8),
    .imem_rdata(imem_rdata8), .redirect(redirect8), .redirect_pc(redirect_pc8),
    .stall_d(stall8), .deq_valid(deq_valid8), .deq_instr(deq_instr8),
    .deq_pcplus4(deq_pcplus48), .count(count8)
  );

  int nvec  = 0;
  int nfail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; redirect = 1'b0; redirect_pc = '0; stall_d = 1'b0;
    #2;
    nvec++; if (count !== 3'd0) begin nfail++; $display("FAIL reset_count got %0d exp 0", count); end
    nvec++; if (deq_valid !== 1'b0) begin nfail++; $display("FAIL reset_valid got %b exp 0", deq_valid); end
    nvec++; if (imem_addr !== 32'h0) begin nfail++; $display("FAIL reset_pc got %h exp 0", imem_addr); end
    nvec++; if (deq_instr !== 32'h0) begin nfail++; $display("FAIL reset_instr got %h exp 0", deq_instr); end
    nvec++; if (deq_pcplus4 !== 32'h0) begin nfail++; $display("FAIL reset_pcplus4 got %h exp 0", deq_pcplus4); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_stream();
    tick();
    nvec++; if (deq_valid !== 1'b1) begin nfail++; $display("FAIL stream_first_valid got %b exp 1", deq_valid); end
    for (int i = 0; i < 6; i++) begin
      nvec++; if (deq_instr !== 32'(4*i)) begin nfail++; $display("FAIL stream_instr[%0d] got %h exp %h", i, deq_instr, 32'(4*i)); end
      nvec++; if (deq_pcplus4 !== 32'(4*i+4)) begin nfail++; $display("FAIL stream_pcplus4[%0d] got %h exp %h", i, deq_pcplus4, 32'(4*i+4)); end
      nvec++; if (count !== 3'd1) begin nfail++; $display("FAIL stream_count[%0d] got %0d exp 1", i, count); end
      tick();
    end
  endtask

  task automatic test_stall_fill();
    pulse_reset();
    stall_d = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      nvec++; if (count !== 3'((k > 4) ? 4 : k)) begin nfail++; $display("FAIL fill_count[%0d] got %0d exp %0d", k, count, (k > 4) ? 4 : k); end
    end
    nvec++; if (imem_en !== 1'b0) begin nfail++; $display("FAIL full_imem_en got %b exp 0", imem_en); end
    nvec++; if (imem_addr !== 32'h10) begin nfail++; $display("FAIL full_pc_frozen got %h exp 10", imem_addr); end
    nvec++; if (deq_pcplus4 !== 32'h4) begin nfail++; $display("FAIL full_head_pcplus4 got %h exp 4", deq_pcplus4); end
    stall_d = 1'b0;
    #1;
    nvec++; if (imem_en !== 1'b1) begin nfail++; $display("FAIL full_pop_imem_en got %b exp 1", imem_en); end
    for (int j = 0; j < 5; j++) begin
      nvec++; if (deq_instr !== 32'(4*j)) begin nfail++; $display("FAIL drain_instr[%0d] got %h exp %h", j, deq_instr, 32'(4*j)); end
      tick();
      if (j == 0) begin
        nvec++; if (count !== 3'd4) begin nfail++; $display("FAIL full_pop_count got %0d exp 4", count); end
        nvec++; if (imem_addr !== 32'h14) begin nfail++; $display("FAIL full_pop_pc got %h exp 14", imem_addr); end
      end
    end
  endtask

  task automatic test_redirect();
    pulse_reset();
    stall_d = 1'b1;
    repeat (3) tick();
    nvec++; if (count !== 3'd3) begin nfail++; $display("FAIL redir_pre_count got %0d exp 3", count); end
    redirect = 1'b1; redirect_pc = 32'h100;
    #1;
    nvec++; if (imem_en !== 1'b0) begin nfail++; $display("FAIL redir_imem_en got %b exp 0", imem_en); end
    tick();
    redirect = 1'b0;
    #1;
    nvec++; if (count !== 3'd0) begin nfail++; $display("FAIL redir_count got %0d exp 0", count); end
    nvec++; if (deq_valid !== 1'b0) begin nfail++; $display("FAIL redir_valid got %b exp 0", deq_valid); end
    nvec++; if (imem_addr !== 32'h100) begin nfail++; $display("FAIL redir_pc got %h exp 100", imem_addr); end
    tick();
    nvec++; if (deq_pcplus4 !== 32'h104) begin nfail++; $display("FAIL redir_pcplus4 got %h exp 104", deq_pcplus4); end
    nvec++; if (deq_instr !== 32'h100) begin nfail++; $display("FAIL redir_instr got %h exp 100", deq_instr); end
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    stall_d = 1'b1;
    repeat (2) tick();
    nvec++; if (count !== 3'd2) begin nfail++; $display("FAIL mid_pre_count got %0d exp 2", count); end
    reset = 1'b0;
    #1;
    nvec++; if (deq_valid !== 1'b0) begin nfail++; $display("FAIL mid_valid got %b exp 0", deq_valid); end
    nvec++; if (count !== 3'd0) begin nfail++; $display("FAIL mid_count got %0d exp 0", count); end
    nvec++; if (imem_addr !== 32'h0) begin nfail++; $display("FAIL mid_pc got %h exp 0", imem_addr); end
    reset = 1'b1; stall_d = 1'b0;
    tick();
    nvec++; if (deq_pcplus4 !== 32'h4) begin nfail++; $display("FAIL mid_first_pcplus4 got %h exp 4", deq_pcplus4); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp;
    reset8 = 1'b0; stall8 = 1'b1; redirect8 = 1'b0; redirect_pc8 = '0;
    #1;
    reset8 = 1'b1;
    #1;
    nvec++; if (imem_addr8 !== 32'hFFFF_FFF8) begin nfail++; $display("FAIL wrap_pc0 got %h exp fffffff8", imem_addr8); end
    tick();
    nvec++; if (imem_addr8 !== 32'hFFFF_FFFC) begin nfail++; $display("FAIL wrap_pc1 got %h exp fffffffc", imem_addr8); end
    tick();
    nvec++; if (imem_addr8 !== 32'h0) begin nfail++; $display("FAIL wrap_pc2 got %h exp 0", imem_addr8); end
    repeat (6) tick();
    nvec++; if (count8 !== 4'd8) begin nfail++; $display("FAIL wrap_full_count got %0d exp 8", count8); end
    nvec++; if (imem_addr8 !== 32'h18) begin nfail++; $display("FAIL wrap_full_pc got %h exp 18", imem_addr8); end
    stall8 = 1'b0;
    for (int j = 0; j < 12; j++) begin
      exp = 32'hFFFF_FFF8 + 32'(4*j);
      nvec++; if (deq_instr8 !== exp) begin nfail++; $display("FAIL wrap_instr[%0d] got %h exp %h", j, deq_instr8, exp); end
      nvec++; if (deq_pcplus48 !== exp + 32'h4) begin nfail++; $display("FAIL wrap_pcplus4[%0d] got %h exp %h", j, deq_pcplus48, exp + 32'h4); end
      tick();
    end
    nvec++; if (count8 !== 4'd8) begin nfail++; $display("FAIL wrap_steady_count got %0d exp 8", count8); end
  endtask

  initial begin
    reset8 = 1'b0; stall8 = 1'b1; redirect8 = 1'b0; redirect_pc8 = '0;
    test_reset();
    test_stream();
    test_stall_fill();
    test_redirect();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
